// File: rtl/axis_word_emitter_if.sv
// AXI4-Stream bundle (tdata/tvalid/tready/tlast) for axis_word_emitter.
// master drives data/valid/last; slave drives ready.
interface axis_word_emitter_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic                        tready;
  logic                        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_word_emitter.sv
// Trigger-edge launched AXI4-Stream burst of a latched configuration word.
// Optional AXIS_EMITTER_INCR_EN: ramp mode, beat k carries cfg_data + k.
module axis_word_emitter #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_data,
  input  logic [CNT_WIDTH-1:0]        cfg_count,
  input  logic                        trigger,
  axis_word_emitter_if.master         m_axis,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_WIDTH-1:0]        sent_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                      state;
  logic                        trigger_q;
  logic                        trig_edge;
  logic [AXIS_TDATA_WIDTH-1:0] data_reg;
  logic [CNT_WIDTH-1:0]        remaining;
  logic                        tvalid_r;
  logic                        tlast_r;
  logic                        beat_ok;

  assign trig_edge = trigger & ~trigger_q;
  assign beat_ok   = tvalid_r & m_axis.tready;

  assign m_axis.tdata  = data_reg;
  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tlast  = tlast_r;

  // trigger_q resets high so a trigger already asserted at release is not an edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      trigger_q  <= 1'b1;
      data_reg   <= '0;
      remaining  <= '0;
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_count <= '0;
    end else begin
      trigger_q <= trigger;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_edge) begin
            sent_count <= '0;
            if (cfg_count != '0) begin
              data_reg  <= cfg_data;
              remaining <= cfg_count;
              tvalid_r  <= 1'b1;
              tlast_r   <= (cfg_count == CNT_WIDTH'(1));
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (beat_ok) begin
            sent_count <= sent_count + CNT_WIDTH'(1);
            remaining  <= remaining - CNT_WIDTH'(1);
`ifdef AXIS_EMITTER_INCR_EN
            data_reg   <= data_reg + AXIS_TDATA_WIDTH'(1);
`endif
            if (tlast_r) begin
              tvalid_r <= 1'b0;
              tlast_r  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              // next beat is last when two beats were outstanding before this one
              tlast_r <= (remaining == CNT_WIDTH'(2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_word_emitter.md
Name: axis_word_emitter

Overview:
- AXI4-Stream master source: on a trigger edge, latches a configuration word and emits it as a burst of cfg_count beats on m_axis, with full tvalid/tready backpressure.
- Transmit-side counterpart of the stream-snapshot sink: turns register or config-bus values into stream beats for DMA, DAC or loopback paths.
- Status outputs report burst activity and completion.

Parameters:
- AXIS_TDATA_WIDTH, 32, width of cfg_data and m_axis_tdata.
- CNT_WIDTH, 16, width of cfg_count and sent_count.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- cfg_data  in  AXIS_TDATA_WIDTH  word to emit; sampled only on trigger edge.
- cfg_count  in  CNT_WIDTH  beats per burst; sampled only on trigger edge.
- trigger  in  1  level input; a rising edge starts a burst.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from downstream.
- m_axis_tlast  out  1  high on the final beat of each burst.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse after the last beat is accepted.
- sent_count  out  CNT_WIDTH  beats accepted in the current or most recent burst.

Behaviour:
- Reset (async assert, sync-released by aclk):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, sent_count=0.
  - Internal trigger_q=1, so a trigger already high at reset release does NOT start a burst; a genuine low-to-high transition is required.
- Edge detect: edge = trigger & ~trigger_q; trigger_q <= trigger every cycle.
- FSM states: IDLE, RUN.
- IDLE:
  - On edge with cfg_count != 0: latch data_reg <= cfg_data and remaining <= cfg_count; clear sent_count to 0; go to RUN.
  - m_axis_tvalid=1 and busy=1 from the next cycle (latency 1 cycle from the edge sample).
  - On edge with cfg_count == 0: no-op. Stay IDLE; no tvalid, no done; sent_count cleared to 0.
- RUN:
  - m_axis_tvalid=1; m_axis_tdata=data_reg; m_axis_tlast = (remaining == 1).
  - Handshake when tvalid & tready: sent_count += 1, remaining -= 1.
  - If that handshake was on the tlast beat: go to IDLE next cycle with tvalid=0, busy=0, done=1 for exactly one cycle.
  - While tvalid=1 and tready=0: tdata and tlast hold stable (AXIS rule); tvalid never deasserts mid-burst.
  - Trigger edges during RUN are ignored and not queued. cfg_data and cfg_count changes during RUN have no effect.
- Back-to-back bursts: an edge in the same cycle that done is high (FSM already in IDLE) starts a new burst; tvalid rises the next cycle.
- cfg_count = all ones (65535 at default) emits 65535 beats; no wrap. sent_count reaches 65535.
- Throughput: 1 beat/cycle with tready held high. A burst of N beats takes N cycles of tvalid.
- Reset mid-burst: tvalid drops immediately (async), the remaining burst is abandoned, and done is not pulsed.
- sent_count holds its final value in IDLE until the next accepted trigger edge.

Optional Feature:
- Macro AXIS_EMITTER_INCR_EN.
- Defined: ramp mode. data_reg increments by 1 (modulo 2^AXIS_TDATA_WIDTH) after each accepted beat, so beat k carries cfg_data + k. Wraps silently at all-ones to 0.
- Not defined: every beat carries the latched cfg_data unchanged. No adder is synthesised.

Test Plan:
- Single burst: cfg_data=0xDEADBEEF, cfg_count=4, tready=1, pulse trigger -> tvalid high 4 consecutive cycles starting 1 cycle after edge sample, tdata=0xDEADBEEF each beat, tlast on beat 4 only, done pulse 1 cycle later, sent_count=4.
- Backpressure: cfg_count=3, tready toggles 1,0,0,1,0,1 -> exactly 3 handshakes; tdata/tlast stable during stalls; tvalid never drops before beat 3 accepted.
- Zero/ignored triggers: cfg_count=0 edge -> no tvalid, no done. Then cfg_count=5 burst with extra trigger edges and cfg_data change mid-burst -> exactly 5 beats of original data, no second burst.
- Reset behaviour: hold trigger=1 through reset release -> no burst. Start cfg_count=10, assert aresetn=0 after beat 3 -> tvalid=0 immediately, sent_count=0, done never pulses.
- Back-to-back: raise trigger in the done cycle with cfg_count=2 -> new burst tvalid next cycle, 2 beats, second done pulse.
- Ramp (AXIS_EMITTER_INCR_EN): cfg_data=0xFFFFFFFE, cfg_count=4 -> tdata 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; without macro all four beats = 0xFFFFFFFE.
